mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store ports.
// Optional MEM_CTRL_ROUND_ROBIN_EN: alternate tie grants; default is fixed data priority.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        inst_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_res,
    input  logic        data_valid,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_value,
    output logic        data_ready,
    output logic [31:0] data_res,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INST_RD,
        S_DATA_RD,
        S_DATA_WR,
        S_IO_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_val;
    logic [31:0] r_buf;
    logic [31:0] r_a;
    logic [7:0]  r_dout;
    logic        r_wr;
    logic        r_iready;
    logic        r_dready;
    logic [31:0] r_ires;
    logic [31:0] r_dres;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;
    logic [2:0]  r_cap;
    logic        r_wait;
    logic        r_sext;
    logic        r_io;

    logic        w_grant;
    logic        w_pick_data;
    logic        w_new_io;
    logic        w_new_go;
    logic        w_rd_last;
    logic        w_wr_last;
    logic        w_wr_stall;
    logic [31:0] w_word;
    logic [31:0] w_ext;
    logic [31:0] w_issue_a;
    logic [7:0]  w_issue_d;
    logic [2:0]  w_new_n;

    function automatic logic [2:0] f_nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_grant = (r_state == S_IDLE)
                   && (inst_valid || data_valid)
                   && !rob_clear;

`ifdef MEM_CTRL_ROUND_ROBIN_EN
    logic r_prio_inst;

    assign w_pick_data = data_valid
                       && !(inst_valid && r_prio_inst);

    // Favour the port that did not finish the last transaction.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_prio_inst <= 1'b0;
        end else if (rdy_in) begin
            if ((r_state == S_INST_RD || r_state == S_DATA_RD)
                && !rob_clear && w_rd_last)
                r_prio_inst <= (r_state == S_DATA_RD);
            else if (r_state == S_DATA_WR && w_wr_last)
                r_prio_inst <= 1'b1;
        end
    end
`else
    assign w_pick_data = data_valid;
`endif

    assign w_new_io   = (data_addr[17:16] == 2'b11);
    assign w_new_go   = !(w_new_io && io_buffer_full);
    assign w_new_n    = w_pick_data ? f_nbytes(data_size[1:0])
                                    : 3'd4;
    assign w_rd_last  = !r_wait && (r_cap == r_n - 3'd1);
    assign w_wr_last  = (r_cnt == r_n);
    assign w_wr_stall = r_io && io_buffer_full;
    assign w_issue_a  = r_addr + {29'd0, r_cnt};
    assign w_issue_d  = r_val[{r_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        w_word = r_buf;
        w_word[{r_cap[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_ext = w_word;
        unique case (1'b1)
            (r_n == 3'd1):
                w_ext = {{24{r_sext & w_word[7]}}, w_word[7:0]};
            (r_n == 3'd2):
                w_ext = {{16{r_sext & w_word[15]}}, w_word[15:0]};
            default: w_ext = w_word;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (!w_pick_data)  w_next = S_INST_RD;
                    else if (data_wr)  w_next = S_DATA_WR;
                    else               w_next = S_DATA_RD;
                end
            end
            S_INST_RD, S_DATA_RD: begin
                if (rob_clear || w_rd_last) w_next = S_IDLE;
            end
            S_DATA_WR: begin
                if (w_wr_last) w_next = r_io ? S_IO_GAP : S_IDLE;
            end
            S_IO_GAP: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            r_state <= S_IDLE;
        else if (rdy_in)
            r_state <= w_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_addr   <= '0;
            r_val    <= '0;
            r_buf    <= '0;
            r_a      <= '0;
            r_dout   <= '0;
            r_wr     <= 1'b0;
            r_iready <= 1'b0;
            r_dready <= 1'b0;
            r_ires   <= '0;
            r_dres   <= '0;
            r_n      <= '0;
            r_cnt    <= '0;
            r_cap    <= '0;
            r_wait   <= 1'b0;
            r_sext   <= 1'b0;
            r_io     <= 1'b0;
        end else if (rdy_in) begin
            r_iready <= 1'b0;
            r_dready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr <= w_pick_data ? data_addr : inst_addr;
                        r_val  <= data_value;
                        r_n    <= w_new_n;
                        r_sext <= data_size[2];
                        r_io   <= w_pick_data && data_wr && w_new_io;
                        r_buf  <= '0;
                        r_cap  <= '0;
                        r_wait <= 1'b1;
                        if (w_pick_data && data_wr) begin
                            if (w_new_go) begin
                                r_a    <= data_addr;
                                r_dout <= data_value[7:0];
                                r_wr   <= 1'b1;
                                r_cnt  <= 3'd1;
                            end else begin
                                r_cnt  <= 3'd0;
                            end
                        end else begin
                            r_a   <= w_pick_data ? data_addr : inst_addr;
                            r_cnt <= 3'd1;
                        end
                    end
                end
                S_INST_RD, S_DATA_RD: begin
                    if (rob_clear) begin
                        r_a <= '0;
                    end else begin
                        if (r_cnt != r_n) begin
                            r_a   <= w_issue_a;
                            r_cnt <= r_cnt + 3'd1;
                        end else begin
                            r_a <= '0;
                        end
                        // mem_din trails mem_a by two edges.
                        if (r_wait) begin
                            r_wait <= 1'b0;
                        end else begin
                            r_buf <= w_word;
                            r_cap <= r_cap + 3'd1;
                            if (w_rd_last) begin
                                if (r_state == S_INST_RD) begin
                                    r_iready <= 1'b1;
                                    r_ires   <= w_word;
                                end else begin
                                    r_dready <= 1'b1;
                                    r_dres   <= w_ext;
                                end
                            end
                        end
                    end
                end
                S_DATA_WR: begin
                    if (w_wr_last) begin
                        r_wr     <= 1'b0;
                        r_a      <= '0;
                        r_dout   <= '0;
                        r_dready <= 1'b1;
                    end else if (w_wr_stall) begin
                        r_wr <= 1'b0;
                    end else begin
                        r_a    <= w_issue_a;
                        r_dout <= w_issue_d;
                        r_wr   <= 1'b1;
                        r_cnt  <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_ready = r_iready;
    assign inst_res   = r_ires;
    assign data_ready = r_dready;
    assign data_res   = r_dres;
    assign mem_a      = r_a;
    assign mem_dout   = r_dout;
    assign mem_wr     = r_wr & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed + randomized bench for mem_ctrl against a byte-array memory model.
// Expected results come from a reference byte array and latency rules.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_addr, inst_res;
    logic        data_valid, data_wr, data_ready;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_value, data_res;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int checks = 0;
    int failures = 0;
    int wr_cycles = 0;

    logic [7:0] init_m [0:262143];
    logic [7:0] refm   [0:262143];
    logic [7:0] ram    [0:262143];
    bit         wrt    [0:262143];

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear),
        .inst_valid(inst_valid), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_res(inst_res),
        .data_valid(data_valid), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_value(data_value), .data_ready(data_ready),
        .data_res(data_res), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Synchronous RAM, frozen together with the rest of the system.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                ram[mem_a[17:0]] <= mem_dout;
                wrt[mem_a[17:0]] <= 1'b1;
                wr_cycles <= wr_cycles + 1;
            end
            mem_din <= wrt[mem_a[17:0]] ? ram[mem_a[17:0]]
                                        : init_m[mem_a[17:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a,
                                             input int n);
        longint r = 0;
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + i;
            r = r + longint'(refm[ai[17:0]]) * (longint'(1) << (8 * i));
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] ext_ref(input logic [31:0] raw,
                                            input int n, input bit sgn);
        longint lim, v;
        if (n >= 4) return raw;
        lim = longint'(1) << (8 * n);
        v = longint'(raw) % lim;
        if (sgn && v >= lim / 2) v = v + (longint'(1) << 32) - lim;
        return v[31:0];
    endfunction

    task automatic put(input logic [31:0] a, input logic [7:0] b);
        init_m[a[17:0]] = b;
        refm[a[17:0]] = b;
    endtask

    // kind: 0 fetch, 1 load, 2 store
    task automatic xact(input int kind, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] v,
                        output logic [31:0] res);
        int n, lat;
        bit done;
        logic [31:0] ai;
        n = (kind == 0) ? 4 : nb(sz[1:0]);
        @(negedge clk_in);
        if (kind == 0) begin
            inst_valid = 1; inst_addr = a;
        end else begin
            data_valid = 1; data_wr = (kind == 2);
            data_size = sz; data_addr = a; data_value = v;
        end
        done = 0; lat = 0; res = '0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk_in); #1;
            if (k <= n) begin
                chk("addr_seq", mem_a, a + k - 1);
                if (kind == 2) begin
                    chk("wr_issue", {31'd0, mem_wr}, 32'd1);
                    chk("wr_byte", {24'd0, mem_dout},
                        {24'd0, v[8*(k-1) +: 8]});
                end
            end
            if (kind == 0 ? inst_ready : data_ready) begin
                done = 1; lat = k;
                res = (kind == 0) ? inst_res : data_res;
            end
        end
        inst_valid = 0; data_valid = 0;
        chk("latency", lat, (kind == 2) ? n + 1 : n + 2);
        if (kind == 2) begin
            chk("wr_end", {31'd0, mem_wr}, 32'd0);
            for (int i = 0; i < n; i++) begin
                ai = a + i;
                refm[ai[17:0]] = v[8*i +: 8];
            end
        end else if (kind == 0) begin
            chk("fetch_res", res, ref_read(a, 4));
        end else begin
            chk("load_res", res, ext_ref(ref_read(a, n), n, sz[2]));
        end
    endtask

    task automatic wait_rdy(output logic [1:0] who, output int k);
        who = 2'b00; k = 0;
        for (int i = 1; i <= 40 && who == 2'b00; i++) begin
            @(posedge clk_in); #1;
            who = {inst_ready, data_ready};
            k = i;
        end
    endtask

    localparam logic [1:0] TIE2 =
`ifdef MEM_CTRL_ROUND_ROBIN_EN
        2'b10;
`else
        2'b01;
`endif

    initial begin
        logic [31:0] res;
        logic [1:0]  who;
        int          k, wc0;
        bit          seen;

        rst_in = 0; rdy_in = 1; rob_clear = 0;
        inst_valid = 0; inst_addr = 0;
        data_valid = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_value = 0; io_buffer_full = 0;
        for (int i = 0; i < 262144; i++) begin
            init_m[i] = 8'h00; refm[i] = 8'h00;
        end
        put(32'h1000, 8'h13); put(32'h1001, 8'h05);
        put(32'h1002, 8'h00); put(32'h1003, 8'h00);
        put(32'h2002, 8'h00); put(32'h2003, 8'h80);
        for (int i = 0; i < 512; i++)
            put(32'h4000 + i, 8'($urandom));

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_inst_res", inst_res, 32'd0);
        chk("rst_data_res", data_res, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_in = 1;
        repeat (2) @(posedge clk_in);

        xact(0, 32'h1000, 3'b010, 32'd0, res);
        chk("fetch_1000", res, 32'h00000513);
        xact(1, 32'h2003, 3'b100, 32'd0, res);
        chk("lb_signed", res, 32'hFFFFFF80);
        xact(1, 32'h2003, 3'b000, 32'd0, res);
        chk("lb_unsigned", res, 32'h00000080);
        xact(1, 32'h2002, 3'b101, 32'd0, res);
        chk("lh_signed", res, 32'hFFFF8000);

        // Simultaneous requests.
        @(negedge clk_in);
        inst_valid = 1; inst_addr = 32'h1000;
        data_valid = 1; data_wr = 0; data_size = 3'b010;
        data_addr = 32'h4000;
        wait_rdy(who, k);
        chk("tie1_winner", {30'd0, who}, 32'd1);
        chk("tie1_res", data_res, ref_read(32'h4000, 4));
        data_valid = 0;
        @(negedge clk_in);
        data_valid = 1;
        wait_rdy(who, k);
        chk("tie2_winner", {30'd0, who}, {30'd0, TIE2});
        if (who[0]) data_valid = 0;
        else        inst_valid = 0;
        wait_rdy(who, k);
        chk("tie2_other", {30'd0, who}, {30'd0, ~TIE2});
        inst_valid = 0; data_valid = 0;
        repeat (2) @(posedge clk_in);

        // I/O store behind a full UART buffer.
        @(negedge clk_in);
        wc0 = wr_cycles;
        io_buffer_full = 1;
        data_valid = 1; data_wr = 1; data_size = 3'b000;
        data_addr = 32'h30000; data_value = 32'h41;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            if (mem_wr || data_ready) seen = 1;
        end
        chk("io_stall", {31'd0, seen}, 32'd0);
        io_buffer_full = 0;
        @(posedge clk_in); #1;
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_addr", mem_a, 32'h30000);
        chk("io_dout", {24'd0, mem_dout}, 32'h41);
        @(posedge clk_in); #1;
        chk("io_ready", {31'd0, data_ready}, 32'd1);
        chk("io_wr_end", {31'd0, mem_wr}, 32'd0);
        data_valid = 0;
        inst_valid = 1; inst_addr = 32'h1000;
        @(posedge clk_in); #1;
        chk("io_gap_addr", mem_a, 32'd0);
        wait_rdy(who, k);
        inst_valid = 0;
        chk("io_gap_lat", k + 1, 32'd7);
        chk("io_count", wr_cycles - wc0, 32'd1);
        chk("io_ram", {24'd0, ram[18'h30000]}, 32'h41);

        // Flush during fetch byte 2.
        @(negedge clk_in);
        inst_valid = 1; inst_addr = 32'h4010;
        repeat (2) @(posedge clk_in);
        #1;
        chk("flush_a1", mem_a, 32'h4011);
        rob_clear = 1; inst_valid = 0;
        @(posedge clk_in); #1;
        rob_clear = 0;
        chk("flush_idle", mem_a, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in); #1;
            if (inst_ready) seen = 1;
        end
        chk("flush_no_ready", {31'd0, seen}, 32'd0);

        // Flush during a store must not abort it.
        @(negedge clk_in);
        data_valid = 1; data_wr = 1; data_size = 3'b010;
        data_addr = 32'h100; data_value = 32'hA1B2C3D4;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(posedge clk_in); #1;
            rob_clear = (i == 2);
            if (data_ready) k = i;
        end
        rob_clear = 0; data_valid = 0;
        chk("st_flush_lat", k, 32'd5);
        chk("st_flush_ram", {ram[18'h103], ram[18'h102],
            ram[18'h101], ram[18'h100]}, 32'hA1B2C3D4);
        for (int i = 0; i < 4; i++)
            refm[18'h100 + i] = data_value[8*i +: 8];

        // Global stall for 3 cycles mid-fetch.
        @(negedge clk_in);
        inst_valid = 1; inst_addr = 32'h4020;
        k = 0; seen = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(posedge clk_in); #1;
            if (i >= 3 && i <= 5 && (mem_wr || mem_a != 32'h4021))
                seen = 1;
            if (i == 2) rdy_in = 0;
            if (i == 5) rdy_in = 1;
            if (inst_ready) begin k = i; res = inst_res; end
        end
        inst_valid = 0;
        chk("stall_hold", {31'd0, seen}, 32'd0);
        chk("stall_lat", k, 32'd9);
        chk("stall_res", res, ref_read(32'h4020, 4));

        // Reset in the middle of a store.
        @(negedge clk_in);
        data_valid = 1; data_wr = 1; data_size = 3'b010;
        data_addr = 32'h500; data_value = 32'h11223344;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 0; data_valid = 0;
        @(posedge clk_in); #1;
        rst_in = 1;
        chk("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mid_a", mem_a, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in); #1;
            if (data_ready) seen = 1;
        end
        chk("rst_mid_ready", {31'd0, seen}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            xact(int'($urandom_range(0, 2)),
                 32'h4000 + $urandom_range(0, 500),
                 3'($urandom_range(0, 7)), $urandom, res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
